// File: rtl/alu_issue_stage_if.sv
// Handshake bundles around the ALU issue stage.
// alu_dec_if carries decoded fields from decode into the stage.
// alu_ex_if carries registered operands and control from the stage to the ALU.

interface alu_dec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;

    modport master (
        output in_valid, opcode, funct3, funct7b5, rs1_data, rs2_data, imm, rd_addr,
        input  in_ready
    );
    modport slave (
        input  in_valid, opcode, funct3, funct7b5, rs1_data, rs2_data, imm, rd_addr,
        output in_ready
    );
endinterface

interface alu_ex_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_control;
    logic [4:0]      rd_out;
    logic            reg_write;
    logic            is_branch;
    logic            illegal;

    modport master (
        output out_valid, alu_a, alu_b, alu_control, rd_out, reg_write, is_branch, illegal,
        input  out_ready
    );
    modport slave (
        input  out_valid, alu_a, alu_b, alu_control, rd_out, reg_write, is_branch, illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I ALU-class instructions into a 3-bit ALU
// control code, picks operand B, and holds the result in a single-entry
// pipeline register with valid/ready, stall and flush. Two saturating event
// counters record accepted legal and illegal instructions.

module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_dec_if.slave         dec,
    alu_ex_if.master         ex,
    input  logic             flush,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             valid_reg;
    logic [XLEN-1:0]  a_reg;
    logic [XLEN-1:0]  b_reg;
    logic [2:0]       ctrl_reg;
    logic [4:0]       rd_reg;
    logic             wr_reg;
    logic             br_reg;
    logic             ill_reg;
    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] illegal_reg;

    logic [2:0]       ctrl_next;
    logic [XLEN-1:0]  b_next;
    logic             wr_next;
    logic             br_next;
    logic             ill_next;
    logic             accept;
    logic             in_ready;

    // The register can take a new entry when it is empty or being consumed.
    assign in_ready     = !valid_reg || ex.out_ready;
    assign dec.in_ready = in_ready;
    assign accept       = dec.in_valid && in_ready && !flush;

    // Decode opcode/funct into ALU control, operand B and writeback/branch flags.
    always_comb begin
        ctrl_next = ALU_ADD;
        b_next    = '0;
        wr_next   = 1'b0;
        br_next   = 1'b0;
        ill_next  = 1'b0;
        case (dec.opcode)
            OP_R, OP_I: begin
                b_next  = (dec.opcode == OP_R) ? dec.rs2_data : dec.imm;
                wr_next = 1'b1;
                case (dec.funct3)
                    3'b000:  ctrl_next = (dec.opcode == OP_R && dec.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  ctrl_next = ALU_AND;
                    3'b110:  ctrl_next = ALU_OR;
                    3'b100:  ctrl_next = ALU_XOR;
                    3'b010:  ctrl_next = ALU_SLT;
                    default: ill_next  = 1'b1;
                endcase
            end
            OP_LOAD: begin
                b_next  = dec.imm;
                wr_next = 1'b1;
            end
            OP_STORE: begin
                b_next = dec.imm;
            end
            OP_BRANCH: begin
                if (dec.funct3 == 3'b000 || dec.funct3 == 3'b001) begin
                    ctrl_next = ALU_SUB;
                    b_next    = dec.rs2_data;
                    br_next   = 1'b1;
                end else begin
                    ill_next = 1'b1;
                end
            end
            default: ill_next = 1'b1;
        endcase
        // Unsupported encodings issue as a harmless ADD with B=0 and no side effects.
        if (ill_next) begin
            ctrl_next = ALU_ADD;
            b_next    = '0;
            wr_next   = 1'b0;
            br_next   = 1'b0;
        end
        // x0 is never written.
        if (dec.rd_addr == 5'd0) begin
            wr_next = 1'b0;
        end
    end

    // Pipeline register: flush empties it, accept loads it, an idle consumer drains it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            ctrl_reg  <= ALU_ADD;
            rd_reg    <= '0;
            wr_reg    <= 1'b0;
            br_reg    <= 1'b0;
            ill_reg   <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            a_reg     <= dec.rs1_data;
            b_reg     <= b_next;
            ctrl_reg  <= ctrl_next;
            rd_reg    <= dec.rd_addr;
            wr_reg    <= wr_next;
            br_reg    <= br_next;
            ill_reg   <= ill_next;
        end else if (in_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Saturating event counters, stepped only by accepted instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_reg  <= '0;
            illegal_reg <= '0;
        end else if (accept) begin
            if (ill_next) begin
                if (illegal_reg != CNT_MAX) illegal_reg <= illegal_reg + 1'b1;
            end else begin
                if (issued_reg != CNT_MAX) issued_reg <= issued_reg + 1'b1;
            end
        end
    end

    assign ex.out_valid   = valid_reg;
    assign ex.alu_a       = a_reg;
    assign ex.alu_b       = b_reg;
    assign ex.alu_control = ctrl_reg;
    assign ex.rd_out      = rd_reg;
    assign ex.reg_write   = wr_reg;
    assign ex.is_branch   = br_reg;
    assign ex.illegal     = ill_reg;
    assign issued_cnt     = issued_reg;
    assign illegal_cnt    = illegal_reg;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX producer for the execute-stage ALU. It decodes RV32I opcode/funct fields into the 3-bit ALUControl encoding, selects operand B (register or immediate), and registers the operands and control into a single-entry pipeline register with valid/ready handshake, stall and flush. It sits between decode and the ALU and drives the ALU's A, B and ALUControl inputs. It also carries two saturating event counters for perf/debug.

Parameters:
XLEN, 32, operand/result width
CNT_W, 16, width of the issued-op and illegal-op counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage can accept this cycle
opcode  input  7  instr[6:0]
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
rs1_data  input  XLEN  register file read port 1
rs2_data  input  XLEN  register file read port 2
imm  input  XLEN  sign-extended immediate from the immediate generator
rd_addr  input  5  destination register
flush  input  1  kill the held and incoming instruction (branch redirect)
out_ready  input  1  execute stage accepts (0 = stall)
out_valid  output  1  A/B/ALUControl valid
alu_a  output  XLEN  ALU operand A
alu_b  output  XLEN  ALU operand B
alu_control  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT
rd_out  output  5  registered destination
reg_write  output  1  writeback enable
is_branch  output  1  ALU result consumed as compare (Zero flag)
illegal  output  1  unsupported encoding held
issued_cnt  output  CNT_W  accepted legal instructions, saturating
illegal_cnt  output  CNT_W  accepted illegal instructions, saturating

Behaviour:
- Reset (rst=0, async): out_valid=0, all data/control outputs 0, counters 0. Reset mid-handshake drops the held instruction; no partial state survives.
- in_ready = !out_valid | out_ready (combinational; independent of flush).
- Accept = in_valid & in_ready & !flush. Accept loads the register on the next edge; latency 1 cycle, throughput 1/cycle.
- Stall: out_valid=1 & out_ready=0 -> all outputs hold bit-stable; in_ready=0.
- Drain: in_ready=1 & no accept -> out_valid<=0 (other outputs may hold).
- Flush: out_valid<=0 next edge; overrides accept and stall; incoming instruction dropped; counters unchanged.
- Decode (alu_a=rs1_data always):
  - 0110011 R: f3 000 -> ADD, or SUB if funct7b5; 111 AND; 110 OR; 100 XOR; 010 SLT; B=rs2; reg_write=1.
  - 0010011 I: same f3 map, funct7b5 ignored (never SUB); B=imm; reg_write=1.
  - 0000011 load: ADD, B=imm, reg_write=1.
  - 0100011 store: ADD, B=imm, reg_write=0.
  - 1100011 branch, f3 000/001: SUB, B=rs2, reg_write=0, is_branch=1.
  - Any other opcode/f3 (incl. f3 001/011/101 R/I, other branch f3): illegal=1, ADD, B=0, reg_write=0, is_branch=0.
- rd_addr=0 forces reg_write=0.
- Counters update only on accept: legal -> issued_cnt+1, illegal -> illegal_cnt+1; both saturate at all-ones, no wrap.

Test Plan:
- Reset: rst low mid-stream with out_valid=1 -> out_valid=0, counters 0 immediately; first accept after release appears one cycle later.
- R-type SUB: opcode 0110011, f3 000, funct7b5=1, rs1=10, rs2=3, rd=5 -> next cycle alu_control=001, A=10, B=3, reg_write=1; ADDI with funct7b5=1, imm=-1 -> 000, B=0xFFFFFFFF.
- Stall: out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged; release -> next instruction issues the following cycle, issued_cnt +2 total.
- Flush: flush=1 together with in_valid and out_valid=1 -> out_valid=0 next cycle, issued_cnt unchanged.
- Illegal/x0: opcode 0110111 -> illegal=1, reg_write=0, illegal_cnt+1; ADD with rd=0 -> reg_write=0.
- Saturation: CNT_W=4, 17 legal accepts -> issued_cnt=15.
